// File: rtl/spi_reg_ctrl_if.sv
// SPI pin bundle between an external host and the register controller.
// All three pins are asynchronous to the peripheral's system clock.
interface spi_reg_ctrl_if;
    logic sclk;
    logic copi;
    logic ncs;

    modport master (output sclk, output copi, output ncs);
    modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI (mode 0, MSB first) write-only register bank: 16-bit frames {rw, addr, data}
// update the output-enable, PWM-enable and duty-cycle registers.
module spi_reg_ctrl #(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_reg_ctrl_if.slave      i_spi,
    output logic [7:0]         o_en_reg_out_7_0,
    output logic [7:0]         o_en_reg_out_15_8,
    output logic [7:0]         o_en_reg_pwm_7_0,
    output logic [7:0]         o_en_reg_pwm_15_8,
    output logic [7:0]         o_pwm_duty_cycle,
    output logic               o_wr_strobe
);

    localparam int FRAME_W = ADDR_W + 9;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    // Top bit of the sclk/ncs chains is the edge-detect history flop; copi needs none.
    logic [SYNC_STAGES:0]   r_sclk_sync;
    logic [SYNC_STAGES:0]   r_ncs_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_ncs_sync  <= '1;
            r_copi_sync <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-1:0], i_spi.sclk};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-1:0],  i_spi.ncs};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], i_spi.copi};
        end
    end

    logic w_ncs, w_copi, w_sclk_rise, w_ncs_rise, w_ncs_fall;
    assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
    assign w_copi      = r_copi_sync[SYNC_STAGES-1];
    assign w_sclk_rise =  r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_sync[SYNC_STAGES];
    assign w_ncs_rise  =  w_ncs & ~r_ncs_sync[SYNC_STAGES];
    assign w_ncs_fall  = ~w_ncs &  r_ncs_sync[SYNC_STAGES];

    state_t               r_state;
    logic [FRAME_W-1:0]   r_shreg;
    logic [CNT_W-1:0]     r_cnt;
    logic [7:0]           r_regs [NUM_REGS];
    logic                 r_wr_strobe;

    logic [ADDR_W-1:0] w_addr;
    logic              w_frame_ok;
    assign w_addr     = r_shreg[FRAME_W-2 -: ADDR_W];
    assign w_frame_ok = (r_cnt == CNT_W'(FRAME_W)) && r_shreg[FRAME_W-1] &&
                        (w_addr < ADDR_W'(NUM_REGS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_wr_strobe <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_wr_strobe <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ncs_fall) begin
                        r_state <= SHIFT;
                        r_shreg <= '0;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    // ncs rising wins over a coincident sclk edge, so that bit is dropped.
                    if (w_ncs_rise) begin
                        r_state <= w_frame_ok ? COMMIT : IDLE;
                    end else if (w_sclk_rise && !w_ncs && r_cnt != CNT_W'(FRAME_W)) begin
                        r_shreg <= {r_shreg[FRAME_W-2:0], w_copi};
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_REGS; i++)
                        if (w_addr == ADDR_W'(i)) r_regs[i] <= r_shreg[7:0];
                    r_wr_strobe <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_en_reg_out_7_0  = r_regs[0];
    assign o_en_reg_out_15_8 = r_regs[1];
    assign o_en_reg_pwm_7_0  = r_regs[2];
    assign o_en_reg_pwm_15_8 = r_regs[3];
    assign o_pwm_duty_cycle  = r_regs[4];
    assign o_wr_strobe       = r_wr_strobe;

endmodule
